// File: rtl/spmul_mac.sv
`default_nettype none
// ============================================================================
// Module   : spmul_mac
// Purpose  : Serial/parallel signed multiplier (MSB-first coefficient bits)
//            with scaling, saturation and optional running-sum accumulate.
//            SPMUL_ROUND_EN: round half up before the output shift.
// Revision : 1.0 - initial release
// ============================================================================
module spmul_mac #(
    parameter int SIG_W     = 16,
    parameter int COEF_W    = 10,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = COEF_W - 1,
    parameter int GUARD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_en,
    input  logic [SIG_W-1:0]  sig_in,
    input  logic [COEF_W-1:0] coef_in,
    output logic [OUT_W-1:0]  result_out,
    output logic              sat_out,
    output logic              valid,
    output logic              done
);

    localparam int ACC_W = SIG_W + COEF_W;
    localparam int SUM_W = ACC_W + GUARD_W;
    localparam int SH_W  = SUM_W + 1;
    localparam int CNT_W = $clog2(COEF_W + 1);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(COEF_W - 1);

    localparam logic signed [SH_W-1:0] C_OUT_MAX =
        {{(SH_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SH_W-1:0] C_OUT_MIN =
        {{(SH_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

`ifdef SPMUL_ROUND_EN
    localparam logic signed [SH_W-1:0] C_ROUND =
        (FRAC_BITS > 0) ? (SH_W'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t                    state_q,   state_d;
    logic signed [SIG_W-1:0]   sig_q,     sig_d;
    logic        [COEF_W-1:0]  coef_q,    coef_d;
    logic                      acc_en_q,  acc_en_d;
    logic signed [ACC_W-1:0]   acc_q,     acc_d;
    logic signed [SUM_W-1:0]   run_sum_q, run_sum_d;
    logic        [CNT_W-1:0]   cnt_q,     cnt_d;
    logic signed [OUT_W-1:0]   result_q,  result_d;
    logic                      sat_q,     sat_d;
    logic                      valid_q,   valid_d;

    logic signed [ACC_W-1:0]   w_sig_ext;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SH_W-1:0]    w_pre;
    logic signed [SH_W-1:0]    w_shifted;
    logic signed [OUT_W-1:0]   w_clip;
    logic                      w_sat;

    // The coefficient register shifts left each MUL cycle, so its MSB is
    // always the bit being processed; the first bit carries negative weight.
    always_comb begin
        w_sig_ext = ACC_W'(sig_q);
        if (!coef_q[COEF_W-1]) begin
            w_term = '0;
        end else if (cnt_q == '0) begin
            w_term = -w_sig_ext;
        end else begin
            w_term = w_sig_ext;
        end
        w_acc_next = {acc_q[ACC_W-2:0], 1'b0} + w_term;
    end

    always_comb begin
        w_sum = (acc_en_q ? run_sum_q : '0) + SUM_W'(acc_q);
`ifdef SPMUL_ROUND_EN
        w_pre = SH_W'(w_sum) + C_ROUND;
`else
        w_pre = SH_W'(w_sum);
`endif
        w_shifted = w_pre >>> FRAC_BITS;
        if (w_shifted > C_OUT_MAX) begin
            w_clip = C_OUT_MAX[OUT_W-1:0];
            w_sat  = 1'b1;
        end else if (w_shifted < C_OUT_MIN) begin
            w_clip = C_OUT_MIN[OUT_W-1:0];
            w_sat  = 1'b1;
        end else begin
            w_clip = w_shifted[OUT_W-1:0];
            w_sat  = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        coef_d    = coef_q;
        acc_en_d  = acc_en_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        run_sum_d = run_sum_q;
        result_d  = result_q;
        sat_d     = sat_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sig_d    = sig_in;
                    coef_d   = coef_in;
                    acc_en_d = acc_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                acc_d  = w_acc_next;
                coef_d = {coef_q[COEF_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_BIT) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                // The running sum keeps the unrounded value and wraps freely.
                run_sum_d = w_sum;
                result_d  = w_clip;
                sat_d     = w_sat;
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sig_q     <= '0;
            coef_q    <= '0;
            acc_en_q  <= 1'b0;
            acc_q     <= '0;
            run_sum_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            coef_q    <= coef_d;
            acc_en_q  <= acc_en_d;
            acc_q     <= acc_d;
            run_sum_q <= run_sum_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
        end
    end

    assign result_out = result_q;
    assign sat_out    = sat_q;
    assign valid      = valid_q;
    assign done       = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spmul_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmul_mac
// Purpose  : Self-checking bench for spmul_mac (table vectors, corner
//            sequences, randomized ops against an arithmetic reference).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spmul_mac;

    localparam int SIG_W     = 16;
    localparam int COEF_W    = 10;
    localparam int OUT_W     = 16;
    localparam int FRAC_BITS = COEF_W - 1;
    localparam int GUARD_W   = 4;
    localparam int SUM_W     = SIG_W + COEF_W + GUARD_W;
    localparam int LAT       = COEF_W + 1;
    localparam int TIMEOUT   = 40;

`ifdef SPMUL_ROUND_EN
    localparam int C_R900 = 2;
`else
    localparam int C_R900 = 1;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     acc_en;
    logic signed [SIG_W-1:0]  sig_in;
    logic signed [COEF_W-1:0] coef_in;
    logic [OUT_W-1:0]         result_out;
    logic                     sat_out;
    logic                     valid;
    logic                     done;

    int n_vec = 0;
    int n_err = 0;
    longint m_run = 0;

    spmul_mac #(
        .SIG_W(SIG_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
        .FRAC_BITS(FRAC_BITS), .GUARD_W(GUARD_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
        .sig_in(sig_in), .coef_in(coef_in), .result_out(result_out),
        .sat_out(sat_out), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [SIG_W-1:0]  s;
        logic signed [COEF_W-1:0] c;
        logic                     a;
        int                       exp_r;
        logic                     exp_s;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exact product, guard-width wraparound, floor shift, clip.
    task automatic model(input longint s, input longint c, input logic a,
                         output int er, output logic es);
        longint sum;
        longint sh;
        sum = (a ? m_run : 64'sd0) + s * c;
        sum = (sum <<< (64 - SUM_W)) >>> (64 - SUM_W);
        m_run = sum;
`ifdef SPMUL_ROUND_EN
        sh = (sum + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
        sh = sum >>> FRAC_BITS;
`endif
        if (sh > 32767) begin
            er = 32767; es = 1'b1;
        end else if (sh < -32768) begin
            er = -32768; es = 1'b1;
        end else begin
            er = int'(sh); es = 1'b0;
        end
    endtask

    task automatic do_op(input logic signed [SIG_W-1:0] s,
                         input logic signed [COEF_W-1:0] c, input logic a,
                         output int lat, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; sig_in = s; coef_in = c; acc_en = a;
        @(posedge clk); #1;
        start = 1'b0;
        sig_in = SIG_W'($urandom); coef_in = COEF_W'($urandom); acc_en = 1'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!valid && lat < TIMEOUT) begin
            if (done !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_check(input string nm, input logic signed [SIG_W-1:0] s,
                            input logic signed [COEF_W-1:0] c, input logic a,
                            input int exp_r, input logic exp_s);
        int   lat;
        logic busy_ok;
        do_op(s, c, a, lat, busy_ok);
        chk({nm, ".latency"}, lat, LAT);
        chk({nm, ".done_low_busy"}, busy_ok, 1);
        chk({nm, ".result"}, $signed(result_out), exp_r);
        chk({nm, ".sat"}, sat_out, exp_s);
        chk({nm, ".done_at_valid"}, done, 1);
        @(posedge clk); #1;
        chk({nm, ".valid_pulse"}, valid, 0);
        chk({nm, ".result_hold"}, $signed(result_out), exp_r);
    endtask

    initial begin
        int   er;
        logic es;
        int   lat;
        int   v1;
        int   v2;

        tbl[0] = '{16'sd1000,    10'sd256,  1'b0, 500,    1'b0};
        tbl[1] = '{-16'sd32768, -10'sd512,  1'b0, 32767,  1'b1};
        tbl[2] = '{-16'sd32768,  10'sd511,  1'b0, -32704, 1'b0};
        tbl[3] = '{16'sd300,     10'sd3,    1'b0, C_R900, 1'b0};
        tbl[4] = '{16'sd100,    -10'sd3,    1'b0, -1,     1'b0};
        tbl[5] = '{16'sd1000,    10'sd256,  1'b0, 500,    1'b0};
        tbl[6] = '{16'sd1000,    10'sd256,  1'b1, 1000,   1'b0};
        tbl[7] = '{16'sd1000,    10'sd256,  1'b0, 500,    1'b0};
        tbl[8] = '{-16'sd32768, -10'sd512,  1'b0, 32767,  1'b1};
        tbl[9] = '{-16'sd32768, -10'sd512,  1'b1, 32767,  1'b1};

        rst = 1'b1; start = 1'b0; acc_en = 1'b0; sig_in = '0; coef_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.done", done, 1);
        chk("reset.valid", valid, 0);
        chk("reset.result", $signed(result_out), 0);
        chk("reset.sat", sat_out, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            model(tbl[i].s, tbl[i].c, tbl[i].a, er, es);
            op_check($sformatf("tbl%0d", i), tbl[i].s, tbl[i].c, tbl[i].a,
                     tbl[i].exp_r, tbl[i].exp_s);
        end

        // Start pulsed during MUL must be ignored.
        model(1000, 256, 1'b0, er, es);
        @(negedge clk);
        start = 1'b1; sig_in = 16'sd1000; coef_in = 10'sd256; acc_en = 1'b0;
        lat = -1;
        for (int e = 0; e < TIMEOUT; e++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = e;
                break;
            end
            @(negedge clk);
            start = (e == 3);
            sig_in = 16'sd5; coef_in = 10'sd7; acc_en = 1'b1;
        end
        start = 1'b0;
        chk("midstart.latency", lat, LAT);
        chk("midstart.result", $signed(result_out), er);
        @(posedge clk); #1;

        // Start held high: back-to-back operations.
        model(1000, 256, 1'b0, er, es);
        model(1000, 256, 1'b0, er, es);
        @(negedge clk);
        start = 1'b1; sig_in = 16'sd1000; coef_in = 10'sd256; acc_en = 1'b0;
        v1 = -1; v2 = -1;
        for (int e = 0; e < 2 * TIMEOUT && v2 < 0; e++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (v1 < 0) v1 = e;
                else begin
                    v2 = e;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held.first_latency", v1, LAT);
        chk("held.period", v2 - v1, COEF_W + 2);
        chk("held.result", $signed(result_out), er);
        @(posedge clk); #1;
        chk("held.no_third", done, 1);

        // Reset in the middle of MUL clears everything including run_sum.
        @(negedge clk);
        start = 1'b1; sig_in = 16'sd1000; coef_in = 10'sd256; acc_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.done", done, 1);
        chk("midrst.valid", valid, 0);
        chk("midrst.result", $signed(result_out), 0);
        chk("midrst.sat", sat_out, 0);
        @(negedge clk);
        rst = 1'b0;
        m_run = 0;
        model(1000, 256, 1'b1, er, es);
        op_check("midrst.acc", 16'sd1000, 10'sd256, 1'b1, 500, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic signed [SIG_W-1:0]  rs;
            logic signed [COEF_W-1:0] rc;
            logic                     ra;
            rs = SIG_W'($urandom);
            rc = COEF_W'($urandom);
            ra = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rs = -16'sd32768;
            if (i % 8 == 1) rc = -10'sd512;
            model(rs, rc, ra, er, es);
            op_check($sformatf("rnd%0d", i), rs, rc, ra, er, es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
